// File: rtl/ddr_io_bank.sv
// ddr_io_bank: per-channel pad registers -- synchronised, deglitched DDR input capture
// and registered DDR/SDR output with optional open-drain drive.
module ddr_io_bank #(
    parameter int              WIDTH       = 4,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILTER_LEN  = 3,
    parameter logic [WIDTH-1:0] DDR_OUT    = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] OPEN_DRAIN = {WIDTH{1'b0}},
    parameter logic [WIDTH-1:0] IDLE_LEVEL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ce,
    input  logic             latch,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe,
    input  logic [WIDTH-1:0] d_out_0,
    input  logic [WIDTH-1:0] d_out_1,
    input  logic [WIDTH-1:0] oe,
    output logic [WIDTH-1:0] d_in_0,
    output logic [WIDTH-1:0] d_in_1,
    output logic [WIDTH-1:0] filt_in,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);
    localparam int CW = $clog2(FILTER_LEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_sync;
    logic [SYNC_STAGES:0][WIDTH-1:0]   w_taps;
    logic [WIDTH-1:0][CW-1:0]          r_cnt;
    logic [WIDTH-1:0] w_s, w_low_sel, w_dout;
    logic [WIDTH-1:0] r_din0, r_q1n, r_din1, r_filt, r_rise, r_fall, r_dout0, r_dout1, r_oe;

    // w_taps[k] is the value entering stage k; the top tap is the unheld last stage
    assign w_taps = {r_sync, pin_in};
    assign w_s    = w_taps[SYNC_STAGES];

    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_sync  <= {SYNC_STAGES{IDLE_LEVEL}};
            r_din0  <= IDLE_LEVEL;
            r_din1  <= IDLE_LEVEL;
            r_dout0 <= '0;
            r_oe    <= '0;
        end else if (ce) begin
            r_sync  <= w_taps[SYNC_STAGES-1:0];
            r_din0  <= latch ? r_din0 : w_taps[SYNC_STAGES-1];
            r_din1  <= r_q1n;
            r_dout0 <= d_out_0;
            r_oe    <= oe;
        end

    always_ff @(negedge clk or negedge resetn)
        if (!resetn) begin
            r_q1n   <= IDLE_LEVEL;
            r_dout1 <= '0;
        end else if (ce) begin
            r_q1n   <= pin_in;
            r_dout1 <= d_out_1;
        end

    // Filter watches the unheld chain so latch only freezes d_in_0
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) begin
            r_filt <= IDLE_LEVEL;
            r_cnt  <= '0;
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= '0;
            r_fall <= '0;
            if (ce)
                for (int i = 0; i < WIDTH; i++)
                    if (w_s[i] == r_filt[i])
                        r_cnt[i] <= '0;
                    else if (r_cnt[i] != CNT_LAST)
                        r_cnt[i] <= r_cnt[i] + 1'b1;
                    else begin
                        r_cnt[i]  <= '0;
                        r_filt[i] <= w_s[i];
                        r_rise[i] <= w_s[i];
                        r_fall[i] <= ~w_s[i];
                    end
        end

    assign w_low_sel = DDR_OUT & {WIDTH{~clk}};
    assign w_dout    = (w_low_sel & r_dout1) | (~w_low_sel & r_dout0);
    assign pin_out   = w_dout & ~OPEN_DRAIN;
    assign pin_oe    = r_oe & ~(w_dout & OPEN_DRAIN);
    assign d_in_0    = r_din0;
    assign d_in_1    = r_din1;
    assign filt_in   = r_filt;
    assign rise      = r_rise & {WIDTH{ce}};
    assign fall      = r_fall & {WIDTH{ce}};
endmodule

// File: tb/tb_ddr_io_bank.sv
// tb_ddr_io_bank: directed and randomized checks of ddr_io_bank against a
// queue-based reference model of the pin-facing behaviour.
module tb_ddr_io_bank;
    localparam int S = 2;
    localparam int L = 3;
    localparam logic [3:0] DDR  = 4'b1101;
    localparam logic [3:0] OD   = 4'b1000;
    localparam logic [3:0] IDLE = 4'b0101;

    logic clk = 1'b0;
    logic resetn = 1'b1;
    logic ce = 1'b1;
    logic latch = 1'b0;
    logic [3:0] pin_in = IDLE, d_out_0 = '0, d_out_1 = '0, oe = '0;
    logic [3:0] pin_out, pin_oe, d_in_0, d_in_1, filt_in, rise, fall;

    int checks = 0;
    int errors = 0;

    logic [3:0] hist[$];
    logic [3:0] m_din0, m_din1, m_q1n, m_filt, m_rise, m_fall, m_q0, m_q1, m_oe;
    int run[4];
    logic [3:0] lo_out, lo_oe, lo_exp_out, lo_exp_oe;

    ddr_io_bank #(
        .WIDTH(4), .SYNC_STAGES(S), .FILTER_LEN(L),
        .DDR_OUT(DDR), .OPEN_DRAIN(OD), .IDLE_LEVEL(IDLE)
    ) dut (
        .clk(clk), .resetn(resetn), .ce(ce), .latch(latch),
        .pin_in(pin_in), .pin_out(pin_out), .pin_oe(pin_oe),
        .d_out_0(d_out_0), .d_out_1(d_out_1), .oe(oe),
        .d_in_0(d_in_0), .d_in_1(d_in_1), .filt_in(filt_in),
        .rise(rise), .fall(fall)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout exp finish");
        $fatal(1);
    end

    function automatic logic [3:0] exp_dout(input logic hi);
        return hi ? m_q0 : ((DDR & m_q1) | (~DDR & m_q0));
    endfunction

    function automatic logic [3:0] exp_out(input logic hi);
        return exp_dout(hi) & ~OD;
    endfunction

    function automatic logic [3:0] exp_oe(input logic hi);
        return m_oe & ~(exp_dout(hi) & OD);
    endfunction

    task automatic model_reset;
        hist.delete();
        repeat (S) hist.push_back(IDLE);
        m_din0 = IDLE; m_din1 = IDLE; m_q1n = IDLE; m_filt = IDLE;
        m_rise = '0; m_fall = '0; m_q0 = '0; m_q1 = '0; m_oe = '0;
        foreach (run[i]) run[i] = 0;
    endtask

    task automatic model_neg;
        if (!resetn) model_reset();
        else if (ce) begin
            m_q1n = pin_in;
            m_q1  = d_out_1;
        end
    endtask

    task automatic model_pos;
        logic [3:0] s;
        if (!resetn) begin
            model_reset();
            return;
        end
        m_rise = '0;
        m_fall = '0;
        if (!ce) return;
        s = hist.pop_front();
        hist.push_back(pin_in);
        if (!latch) m_din0 = hist[0];
        m_din1 = m_q1n;
        m_q0 = d_out_0;
        m_oe = oe;
        for (int c = 0; c < 4; c++)
            if (s[c] !== m_filt[c]) begin
                run[c]++;
                if (run[c] == L) begin
                    m_filt[c] = s[c];
                    m_rise[c] = s[c];
                    m_fall[c] = ~s[c];
                    run[c] = 0;
                end
            end else run[c] = 0;
    endtask

    task automatic step(input logic [3:0] p, d0, d1, o, input logic c, l);
        @(negedge clk);
        model_neg();
        #1;
        lo_out = pin_out; lo_oe = pin_oe;
        lo_exp_out = exp_out(1'b0); lo_exp_oe = exp_oe(1'b0);
        #1;
        pin_in = p; d_out_0 = d0; d_out_1 = d1; oe = o; ce = c; latch = l;
        @(posedge clk);
        model_pos();
        #1;
    endtask

    task automatic test_reset;
        #1 resetn = 1'b0;
        model_reset();
        #1;
        checks++; if (d_in_0 !== IDLE) begin errors++; $display("FAIL reset_din0: got %b exp %b", d_in_0, IDLE); end
        checks++; if (filt_in !== IDLE) begin errors++; $display("FAIL reset_filt: got %b exp %b", filt_in, IDLE); end
        checks++; if (d_in_1 !== IDLE) begin errors++; $display("FAIL reset_din1: got %b exp %b", d_in_1, IDLE); end
        checks++; if (pin_oe !== 4'b0000) begin errors++; $display("FAIL reset_oe: got %b exp 0000", pin_oe); end
        checks++; if ((rise | fall) !== 4'b0000) begin errors++; $display("FAIL reset_pulse: got %b exp 0000", rise | fall); end
        repeat (2) step(IDLE, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0);
        checks++; if (pin_oe !== 4'b0000) begin errors++; $display("FAIL reset_held_oe: got %b exp 0000", pin_oe); end
        resetn = 1'b1;
        step(IDLE, '0, '0, '0, 1'b1, 1'b0);
        checks++; if (d_in_0 !== IDLE) begin errors++; $display("FAIL release_din0: got %b exp %b", d_in_0, IDLE); end
        checks++; if (filt_in !== IDLE) begin errors++; $display("FAIL release_filt: got %b exp %b", filt_in, IDLE); end
        checks++; if ((rise | fall | pin_oe) !== 4'b0000) begin errors++; $display("FAIL release_quiet: got %b exp 0000", rise | fall | pin_oe); end
        repeat (4) step(IDLE | 4'b0010, '0, '0, '0, 1'b1, 1'b0);
        resetn = 1'b0;
        model_reset();
        #1;
        checks++; if (d_in_0 !== IDLE) begin errors++; $display("FAIL midcount_din0: got %b exp %b", d_in_0, IDLE); end
        #1 resetn = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            step(IDLE | 4'b0010, '0, '0, '0, 1'b1, 1'b0);
            checks++; if (filt_in[1] !== (i == 5)) begin errors++; $display("FAIL midcount_filt step %0d: got %b exp %b", i, filt_in[1], i == 5); end
            checks++; if (rise[1] !== (i == 5)) begin errors++; $display("FAIL midcount_rise step %0d: got %b exp %b", i, rise[1], i == 5); end
        end
    endtask

    task automatic test_sync;
        int din_at, filt_at, rises, falls;
        din_at = 0; filt_at = 0; rises = 0; falls = 0;
        repeat (8) step(IDLE, '0, '0, '0, 1'b1, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step(IDLE | 4'b0010, '0, '0, '0, 1'b1, 1'b0);
            if (d_in_0[1] && din_at == 0) din_at = i;
            if (filt_in[1] && filt_at == 0) filt_at = i;
            rises += int'(rise[1]);
            falls += int'(|fall);
        end
        checks++; if (din_at != S) begin errors++; $display("FAIL sync_latency: got %0d exp %0d", din_at, S); end
        checks++; if (filt_at != S + L) begin errors++; $display("FAIL filter_latency: got %0d exp %0d", filt_at, S + L); end
        checks++; if (rises != 1) begin errors++; $display("FAIL rise_count: got %0d exp 1", rises); end
        checks++; if (falls != 0) begin errors++; $display("FAIL fall_count: got %0d exp 0", falls); end
    endtask

    task automatic test_glitch;
        int rises, falls, highs;
        repeat (8) step(IDLE, '0, '0, '0, 1'b1, 1'b0);
        for (int w = 1; w <= 3; w++) begin
            rises = 0; falls = 0; highs = 0;
            repeat (w) begin
                step(IDLE | 4'b0010, '0, '0, '0, 1'b1, 1'b0);
                rises += int'(rise[1]); falls += int'(fall[1]); highs += int'(filt_in[1]);
            end
            repeat (8) begin
                step(IDLE, '0, '0, '0, 1'b1, 1'b0);
                rises += int'(rise[1]); falls += int'(fall[1]); highs += int'(filt_in[1]);
            end
            checks++; if (rises != (w >= L ? 1 : 0)) begin errors++; $display("FAIL glitch%0d_rise: got %0d exp %0d", w, rises, w >= L ? 1 : 0); end
            checks++; if (falls != (w >= L ? 1 : 0)) begin errors++; $display("FAIL glitch%0d_fall: got %0d exp %0d", w, falls, w >= L ? 1 : 0); end
            checks++; if ((highs != 0) != (w >= L)) begin errors++; $display("FAIL glitch%0d_filt: got %0d high cycles", w, highs); end
        end
    endtask

    task automatic test_ddr_out;
        for (int i = 1; i <= 5; i++) begin
            step(IDLE, 4'b0110, 4'b0000, 4'b0110, 1'b1, 1'b0);
            checks++; if (pin_out[2] !== 1'b1) begin errors++; $display("FAIL ddr_high: got %b exp 1", pin_out[2]); end
            checks++; if (pin_oe[2] !== 1'b1) begin errors++; $display("FAIL ddr_oe: got %b exp 1", pin_oe[2]); end
            checks++; if (pin_out[1] !== 1'b1) begin errors++; $display("FAIL sdr_high: got %b exp 1", pin_out[1]); end
            if (i >= 2) begin
                checks++; if (lo_out[2] !== 1'b0) begin errors++; $display("FAIL ddr_low: got %b exp 0", lo_out[2]); end
                checks++; if (lo_out[1] !== 1'b1) begin errors++; $display("FAIL sdr_low: got %b exp 1", lo_out[1]); end
            end
        end
    endtask

    task automatic test_open_drain;
        logic [3:0] v;
        logic prev;
        v = 4'b1010;
        prev = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(IDLE, {v[i], 3'b0}, {v[i], 3'b0}, 4'b1000, 1'b1, 1'b0);
            checks++; if (pin_out[3] !== 1'b0) begin errors++; $display("FAIL od_out: got %b exp 0", pin_out[3]); end
            checks++; if (pin_oe[3] !== ~v[i]) begin errors++; $display("FAIL od_oe_high: got %b exp %b", pin_oe[3], ~v[i]); end
            if (i >= 1) begin
                checks++; if (lo_oe[3] !== ~prev || lo_out[3] !== 1'b0) begin errors++; $display("FAIL od_low: got oe %b out %b exp oe %b out 0", lo_oe[3], lo_out[3], ~prev); end
            end
            prev = v[i];
        end
        step(IDLE, '0, '0, '0, 1'b1, 1'b0);
        checks++; if (pin_oe[3] !== 1'b0) begin errors++; $display("FAIL od_release: got %b exp 0", pin_oe[3]); end
    endtask

    task automatic test_latch_ce;
        repeat (6) step(4'b0000, '0, '0, '0, 1'b1, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            step({3'b111, 1'(i % 2)}, '0, '0, '0, 1'b1, 1'b1);
            checks++; if (d_in_0 !== 4'b0000) begin errors++; $display("FAIL latch_hold step %0d: got %b exp 0000", i, d_in_0); end
            if (i >= 4) begin
                checks++; if (filt_in[3:1] !== (i == 5 ? 3'b111 : 3'b000)) begin errors++; $display("FAIL latch_filt step %0d: got %b", i, filt_in[3:1]); end
            end
        end
        step(4'b1111, '0, '0, '0, 1'b1, 1'b0);
        checks++; if (d_in_0 !== 4'b1111) begin errors++; $display("FAIL latch_resume: got %b exp 1111", d_in_0); end
        repeat (6) step(4'b1111, '0, '0, '0, 1'b1, 1'b0);
        repeat (3) step(4'b0000, '0, '0, '0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom), 1'b0, 1'b0);
            checks++; if (d_in_0 !== 4'b0000 || d_in_1 !== 4'b0000) begin errors++; $display("FAIL ce_freeze_in: got %b/%b exp 0000/0000", d_in_0, d_in_1); end
            checks++; if (filt_in !== 4'b1111) begin errors++; $display("FAIL ce_freeze_filt: got %b exp 1111", filt_in); end
            checks++; if ((rise | fall) !== 4'b0000) begin errors++; $display("FAIL ce_pulse: got %b exp 0000", rise | fall); end
            checks++; if (pin_out !== exp_out(1'b1) || pin_oe !== exp_oe(1'b1)) begin errors++; $display("FAIL ce_freeze_pins: got %b/%b exp %b/%b", pin_out, pin_oe, exp_out(1'b1), exp_oe(1'b1)); end
        end
        step(4'b0000, '0, '0, '0, 1'b1, 1'b0);
        checks++; if (filt_in !== 4'b1111 || fall !== 4'b0000) begin errors++; $display("FAIL ce_resume1: got filt %b fall %b exp 1111 0000", filt_in, fall); end
        step(4'b0000, '0, '0, '0, 1'b1, 1'b0);
        checks++; if (filt_in !== 4'b0000 || fall !== 4'b1111 || rise !== 4'b0000) begin errors++; $display("FAIL ce_resume2: got filt %b fall %b rise %b exp 0000 1111 0000", filt_in, fall, rise); end
    endtask

    task automatic test_random;
        logic [3:0] p;
        p = IDLE;
        for (int i = 0; i < 400; i++) begin
            p = p ^ (4'($urandom) & 4'($urandom) & 4'($urandom));
            step(p, 4'($urandom), 4'($urandom), 4'($urandom), $urandom_range(0, 7) != 0, $urandom_range(0, 5) == 0);
            checks++; if (d_in_0 !== m_din0) begin errors++; $display("FAIL rnd_din0 %0d: got %b exp %b", i, d_in_0, m_din0); end
            checks++; if (d_in_1 !== m_din1) begin errors++; $display("FAIL rnd_din1 %0d: got %b exp %b", i, d_in_1, m_din1); end
            checks++; if (filt_in !== m_filt) begin errors++; $display("FAIL rnd_filt %0d: got %b exp %b", i, filt_in, m_filt); end
            checks++; if (rise !== m_rise || fall !== m_fall) begin errors++; $display("FAIL rnd_pulse %0d: got %b/%b exp %b/%b", i, rise, fall, m_rise, m_fall); end
            checks++; if (pin_out !== exp_out(1'b1) || pin_oe !== exp_oe(1'b1)) begin errors++; $display("FAIL rnd_pin_high %0d: got %b/%b exp %b/%b", i, pin_out, pin_oe, exp_out(1'b1), exp_oe(1'b1)); end
            checks++; if (lo_out !== lo_exp_out || lo_oe !== lo_exp_oe) begin errors++; $display("FAIL rnd_pin_low %0d: got %b/%b exp %b/%b", i, lo_out, lo_oe, lo_exp_out, lo_exp_oe); end
        end
    endtask

    initial begin
        test_reset();
        test_sync();
        test_glitch();
        test_ddr_out();
        test_open_drain();
        test_latch_ce();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
